mul_signed_sequencer: RTL and testbench
=======================================

MUL_SIGNED_SEQUENCER -- requirements
Module: mul_signed_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 100, maximum number of BUSY cycles to wait for multiplier finish before aborting.
REQ-002 Clocking is decided: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-low reset.
REQ-005 inValid  in  1  operand pair offered.
REQ-006 inReady  out  1  block accepts operands this cycle.
REQ-007 a  in  32  multiplicand.
REQ-008 b  in  32  multiplier.
REQ-009 isSigned  in  1  1 means a and b are two's complement; 0 means unsigned.
REQ-010 outValid  out  1  result held on p.
REQ-011 outReady  in  1  consumer takes the result.
REQ-012 p  out  64  product.
REQ-013 timeoutError  out  1  the current result was aborted; qualified by outValid.
REQ-014 mulStart  out  1  drives the unsigned sequential multiplier's positive start/reset input.
REQ-015 mulA, mulB  out  32 each  unsigned magnitudes driven to the multiplier.
REQ-016 mulFinish  in  1  multiplier halt flag.
REQ-017 mulP  in  64  unsigned multiplier product.

Function
REQ-018 The FSM SHALL have the states IDLE, START, BUSY and DONE.
REQ-019 inReady SHALL be 1 only in IDLE; a transfer occurs when inValid and inReady are both 1.
REQ-020 On a transfer the block SHALL register mulA = |a| and mulB = |b| (magnitudes only when isSigned=1), plus negFlag = isSigned & (a[31] ^ b[31]), then enter START.
- For a = 0x80000000 signed, the magnitude SHALL be 0x80000000 (no overflow).
REQ-021 mulA and mulB SHALL stay stable from START until DONE is left.
REQ-022 START SHALL last exactly 1 cycle with mulStart=1, then go to BUSY; mulStart SHALL be 0 in every other state.
REQ-023 In BUSY, mulFinish SHALL be honoured only after it has been sampled 0 at least once since START, so a stale finish from the previous operation is ignored.
REQ-024 On an honoured mulFinish, the block SHALL register p = negFlag ? (~mulP + 1) mod 2^64 : mulP, clear timeoutError, and enter DONE.
REQ-025 A BUSY cycle counter SHALL start at 0 on BUSY entry and increment every BUSY cycle.
- If it reaches TIMEOUT_CYCLES without an honoured finish: p SHALL be 0, timeoutError SHALL be 1, and the FSM enters DONE.
- If both events occur in the same cycle, finish has priority.
REQ-026 outValid SHALL be 1 exactly in DONE; p and timeoutError SHALL hold stable while outValid=1 and outReady=0.
REQ-027 In DONE with outReady=1, the FSM SHALL go to IDLE next cycle.
- The earliest new transfer is the cycle after that.
- inValid in DONE is ignored.
REQ-028 Latency from transfer cycle T: mulStart high at T+1; outValid rises 1 cycle after the honoured-finish cycle.
REQ-029 Signed negation of a zero product SHALL yield 0.

Reset
REQ-030 With rst=0 at a rising edge, the block SHALL enter IDLE from any state, including mid-BUSY or DONE, the next cycle.
REQ-031 Reset values SHALL be:
- inReady=1 after the reset cycle;
- outValid=0, p=0, timeoutError=0, mulStart=0, mulA=0, mulB=0;
- counter=0, negFlag=0.
REQ-032 An in-flight multiplier operation SHALL be abandoned on reset; the next START reinitialises the multiplier.

Verification
REQ-033 Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, isSigned=0 -> p=0xFFFFFFFE00000001, timeoutError=0.
REQ-034 Signed, mixed sign: a=-3 (0xFFFFFFFD), b=7 -> mulA=3, mulB=7, p=0xFFFFFFFFFFFFFFEB (-21).
REQ-035 Signed corner: a=0x80000000, b=0x80000000, isSigned=1 -> p=0x4000000000000000; a=0, b=-5 -> p=0.
REQ-036 Backpressure: hold outReady=0 for 10 cycles in DONE -> p, timeoutError and outValid stable; inReady=0 throughout; IDLE one cycle after outReady=1.
REQ-037 Timeout: model holds mulFinish=0 -> outValid after exactly TIMEOUT_CYCLES BUSY cycles, with p=0 and timeoutError=1; stale mulFinish=1 during START and first BUSY cycle -> not honoured.
REQ-038 Reset mid-BUSY: rst=0 for 1 cycle -> IDLE, outValid=0, mulStart=0; a following a=2, b=3 transfer -> p=6.

Source files
------------

// File: rtl/mul_signed_sequencer_if.sv
// -----------------------------------------------------------------------------
// mul_signed_sequencer_if
//
// Bundles every non-clock signal of mul_signed_sequencer:
//   operand side : inValid, inReady, a[31:0], b[31:0], isSigned
//   result side  : outValid, outReady, p[63:0], timeoutError
//   multiplier   : mulStart, mulA[31:0], mulB[31:0], mulFinish, mulP[63:0]
//
// Handshake rule (both operand and result channels): a word moves on a rising
// clock edge where valid and ready are both 1. The producer keeps valid and
// data stable until that edge; ready may change freely and never depends
// combinationally on valid.
//
// The slave modport is the sequencer's view. The master modport is the view of
// everything around it: the operand producer, the result consumer and the
// unsigned sequential multiplier.
// -----------------------------------------------------------------------------
interface mul_signed_sequencer_if;

    // Operand channel
    logic        inValid;
    logic        inReady;
    logic [31:0] a;
    logic [31:0] b;
    logic        isSigned;

    // Result channel
    logic        outValid;
    logic        outReady;
    logic [63:0] p;
    logic        timeoutError;

    // Unsigned sequential multiplier
    logic        mulStart;
    logic [31:0] mulA;
    logic [31:0] mulB;
    logic        mulFinish;
    logic [63:0] mulP;

    modport slave (
        input  inValid, a, b, isSigned, outReady, mulFinish, mulP,
        output inReady, outValid, p, timeoutError, mulStart, mulA, mulB
    );

    modport master (
        output inValid, a, b, isSigned, outReady, mulFinish, mulP,
        input  inReady, outValid, p, timeoutError, mulStart, mulA, mulB
    );

endinterface

// File: rtl/mul_signed_sequencer.sv
// -----------------------------------------------------------------------------
// mul_signed_sequencer
//
// Wraps an external unsigned sequential 32x32 multiplier so it can be used for
// both signed and unsigned products. Operands are reduced to magnitudes on
// acceptance, the multiplier is started for one cycle, and when it finishes the
// product is negated if the operand signs differed. A watchdog aborts the
// operation if the multiplier never finishes.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst       synchronous, active-low reset
//   bus       mul_signed_sequencer_if.slave (operand, result, multiplier)
//   fsmState  current FSM state for observation (IDLE=0 START=1 BUSY=2 DONE=3)
//
// Parameter:
//   TIMEOUT_CYCLES  number of BUSY cycles allowed before the operation is
//                   aborted with timeoutError=1 and p=0 (must be >= 1)
//
// Timing from an operand transfer on edge T:
//   T+1      START, mulStart=1
//   T+2..    BUSY, waiting for an honoured mulFinish
//   F+1      DONE (outValid=1) where F is the honoured-finish cycle
// -----------------------------------------------------------------------------
module mul_signed_sequencer #(
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    mul_signed_sequencer_if.slave        bus,
    output logic [1:0]                   fsmState
);

    // Counter wide enough to hold TIMEOUT_CYCLES itself.
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] busyCount;
    logic          negFlag;
    // Set once mulFinish has been seen low in BUSY. Until then a high
    // mulFinish is the halt flag left over from the previous operation.
    logic          sawLow;

    // Operand magnitudes. The two's complement negation of 0x80000000 is
    // 0x80000000, which read as unsigned is exactly the wanted magnitude.
    logic [31:0] magA;
    logic [31:0] magB;
    logic        negNext;

    always_comb begin
        magA    = bus.a;
        magB    = bus.b;
        negNext = 1'b0;
        if (bus.isSigned) begin
            if (bus.a[31]) begin
                magA = ~bus.a + 32'd1;
            end
            if (bus.b[31]) begin
                magB = ~bus.b + 32'd1;
            end
            negNext = bus.a[31] ^ bus.b[31];
        end
    end

    logic        finishHonoured;
    logic        timeoutHit;
    logic [63:0] signedProduct;

    assign finishHonoured = bus.mulFinish & sawLow;
    assign timeoutHit     = (busyCount == LAST_COUNT);
    // Negating zero wraps back to zero, so no special case is needed.
    assign signedProduct  = negFlag ? (~bus.mulP + 64'd1) : bus.mulP;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            bus.inReady      <= 1'b1;
            bus.outValid     <= 1'b0;
            bus.p            <= 64'd0;
            bus.timeoutError <= 1'b0;
            bus.mulStart     <= 1'b0;
            bus.mulA         <= 32'd0;
            bus.mulB         <= 32'd0;
            busyCount        <= '0;
            negFlag          <= 1'b0;
            sawLow           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // inReady is 1 throughout IDLE, so inValid alone
                    // marks a transfer here.
                    if (bus.inValid) begin
                        bus.mulA     <= magA;
                        bus.mulB     <= magB;
                        negFlag      <= negNext;
                        bus.inReady  <= 1'b0;
                        bus.mulStart <= 1'b1;
                        state        <= START;
                    end
                end

                START: begin
                    bus.mulStart <= 1'b0;
                    busyCount    <= '0;
                    sawLow       <= 1'b0;
                    state        <= BUSY;
                end

                BUSY: begin
                    // Finish is checked first so it wins over a timeout
                    // landing in the same cycle.
                    if (finishHonoured) begin
                        bus.p            <= signedProduct;
                        bus.timeoutError <= 1'b0;
                        bus.outValid     <= 1'b1;
                        state            <= DONE;
                    end else if (timeoutHit) begin
                        bus.p            <= 64'd0;
                        bus.timeoutError <= 1'b1;
                        bus.outValid     <= 1'b1;
                        state            <= DONE;
                    end else begin
                        busyCount <= busyCount + CW'(1);
                        if (!bus.mulFinish) begin
                            sawLow <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // p and timeoutError are only written in BUSY, so they
                    // hold for as long as the consumer stalls.
                    if (bus.outReady) begin
                        bus.outValid <= 1'b0;
                        bus.inReady  <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign fsmState = state;

endmodule

// File: tb/tb_mul_signed_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_signed_sequencer
//
// Directed bench for mul_signed_sequencer with a behavioural unsigned
// sequential multiplier. Expected products, flags and latencies are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mul_signed_sequencer;

    localparam int TO = 100;

    logic       clk;
    logic       rst;
    logic [1:0] fsmState;

    mul_signed_sequencer_if bus ();

    mul_signed_sequencer #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .fsmState(fsmState)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- multiplier model ----------------
    // After mulStart the finish flag stays high for mdlStale more cycles
    // (stale halt flag), then low, then rises with the product after
    // mdlLatency cycles. mdlHang keeps it from ever finishing.
    int          mdlLatency = 3;
    int          mdlStale   = 0;
    bit          mdlHang    = 1'b0;
    int          mdlCnt;
    bit          mdlActive;
    logic [31:0] mdlA;
    logic [31:0] mdlB;

    always @(posedge clk) begin
        if (!rst) begin
            mdlActive     <= 1'b0;
            mdlCnt        <= 0;
            bus.mulFinish <= 1'b1;
            bus.mulP      <= 64'd0;
        end else if (bus.mulStart) begin
            mdlActive     <= 1'b1;
            mdlCnt        <= 0;
            mdlA          <= bus.mulA;
            mdlB          <= bus.mulB;
            bus.mulFinish <= (mdlStale > 0);
        end else if (mdlActive) begin
            if (!mdlHang && (mdlCnt + 1 >= mdlLatency)) begin
                bus.mulFinish <= 1'b1;
                bus.mulP      <= {32'd0, mdlA} * {32'd0, mdlB};
                mdlActive     <= 1'b0;
            end else begin
                bus.mulFinish <= (mdlCnt + 1 < mdlStale);
            end
            mdlCnt <= mdlCnt + 1;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
        int n;
        n = 0;
        while (!bus.inReady && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", {63'd0, bus.inReady}, 64'd1);
        bus.a        = ta;
        bus.b        = tb;
        bus.isSigned = ts;
        bus.inValid  = 1'b1;
        tick();
        bus.inValid  = 1'b0;
        check("mul_start", {63'd0, bus.mulStart}, 64'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.outValid && n < 300) begin
            tick();
            n++;
        end
        check("out_valid_seen", {63'd0, bus.outValid}, 64'd1);
    endtask

    task automatic consume();
        bus.outReady = 1'b1;
        tick();
        bus.outReady = 1'b0;
        check("idle_in_ready", {63'd0, bus.inReady}, 64'd1);
        check("idle_out_valid", {63'd0, bus.outValid}, 64'd0);
        check("idle_state", {62'd0, fsmState}, 64'd0);
    endtask

    task automatic run_op(input string tag,
                          input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                          input logic [31:0] expMa, input logic [31:0] expMb,
                          input logic [63:0] expP, input logic expTe, input int expN);
        int n;
        send(ta, tb, ts);
        check({tag, "_mulA"}, {32'd0, bus.mulA}, {32'd0, expMa});
        check({tag, "_mulB"}, {32'd0, bus.mulB}, {32'd0, expMb});
        wait_done(n);
        check({tag, "_latency"}, 64'(n), 64'(expN));
        check({tag, "_p"}, bus.p, expP);
        check({tag, "_timeout"}, {63'd0, bus.timeoutError}, {63'd0, expTe});
        consume();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [63:0] heldP;

        rst          = 1'b0;
        bus.inValid  = 1'b0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.isSigned = 1'b0;
        bus.outReady = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_in_ready", {63'd0, bus.inReady}, 64'd1);
        check("rst_out_valid", {63'd0, bus.outValid}, 64'd0);
        check("rst_p", bus.p, 64'd0);
        check("rst_timeout", {63'd0, bus.timeoutError}, 64'd0);
        check("rst_mul_start", {63'd0, bus.mulStart}, 64'd0);
        check("rst_mulA", {32'd0, bus.mulA}, 64'd0);
        check("rst_mulB", {32'd0, bus.mulB}, 64'd0);
        check("rst_state", {62'd0, fsmState}, 64'd0);
        rst = 1'b1;
        tick();
        check("post_rst_in_ready", {63'd0, bus.inReady}, 64'd1);

        // Functional vectors (latency 3 -> outValid 5 edges after transfer)
        run_op("u_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
               32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0, 5);
        run_op("s_m3x7", 32'hFFFFFFFD, 32'd7, 1'b1,
               32'd3, 32'd7, 64'hFFFFFFFFFFFFFFEB, 1'b0, 5);
        run_op("u_fffdx7", 32'hFFFFFFFD, 32'd7, 1'b0,
               32'hFFFFFFFD, 32'd7, 64'h00000006FFFFFFEB, 1'b0, 5);
        run_op("s_minxmin", 32'h80000000, 32'h80000000, 1'b1,
               32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0, 5);
        run_op("s_0xm5", 32'd0, 32'hFFFFFFFB, 1'b1,
               32'd0, 32'd5, 64'd0, 1'b0, 5);
        run_op("s_m2xm3", 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1,
               32'd2, 32'd3, 64'd6, 1'b0, 5);

        // Stale finish during START and first BUSY cycle must be ignored
        mdlStale   = 1;
        mdlLatency = 4;
        run_op("stale", 32'd2, 32'd5, 1'b0, 32'd2, 32'd5, 64'd10, 1'b0, 6);
        mdlStale   = 0;
        mdlLatency = 3;

        // Timeout: TO BUSY cycles after the START cycle
        mdlHang = 1'b1;
        run_op("timeout", 32'd9, 32'd9, 1'b0, 32'd9, 32'd9, 64'd0, 1'b1, TO + 1);
        mdlHang = 1'b0;

        // Backpressure: 10 stalled cycles in DONE, inValid ignored there
        send(32'd7, 32'd6, 1'b0);
        wait_done(n);
        heldP = bus.p;
        check("bp_p_initial", heldP, 64'd42);
        bus.inValid = 1'b1;
        bus.a       = 32'd1;
        bus.b       = 32'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", {63'd0, bus.outValid}, 64'd1);
            check("bp_p", bus.p, 64'd42);
            check("bp_timeout", {63'd0, bus.timeoutError}, 64'd0);
            check("bp_in_ready", {63'd0, bus.inReady}, 64'd0);
        end
        bus.inValid = 1'b0;
        consume();

        // Reset in the middle of BUSY
        mdlHang = 1'b1;
        send(32'd4, 32'd4, 1'b0);
        repeat (5) tick();
        check("mid_busy_state", {62'd0, fsmState}, 64'd2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mrst_out_valid", {63'd0, bus.outValid}, 64'd0);
        check("mrst_mul_start", {63'd0, bus.mulStart}, 64'd0);
        check("mrst_in_ready", {63'd0, bus.inReady}, 64'd1);
        check("mrst_state", {62'd0, fsmState}, 64'd0);
        check("mrst_p", bus.p, 64'd0);
        mdlHang = 1'b0;
        run_op("after_rst", 32'd2, 32'd3, 1'b0, 32'd2, 32'd3, 64'd6, 1'b0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
